// File: rtl/layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// layer_sequencer_if : config port, input stream and output stream bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface layer_sequencer_if #(
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 1,
    parameter int WIDTH       = 8
);
    localparam int AW = $clog2(NUM_OUTPUTS*NUM_INPUTS + NUM_OUTPUTS);

    logic                           cfg_we;
    logic [AW-1:0]                  cfg_addr;
    logic [WIDTH-1:0]               cfg_wdata;
    logic                           cfg_err;
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH*NUM_INPUTS-1:0]    in_values;
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH*NUM_OUTPUTS-1:0]   out_values;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_values, out_ready,
        output cfg_err, in_ready, out_valid, out_values
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_values, out_ready,
        input  cfg_err, in_ready, out_valid, out_values
    );
endinterface

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer : fire/collect controller around one fully-connected layer;
//                   LAYER_SEQ_PERF_EN adds done/timeout performance counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module layer_sequencer #(
    parameter int NUM_INPUTS     = 1,
    parameter int NUM_OUTPUTS    = 1,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    layer_sequencer_if.slave                       bus,
    output logic [WIDTH*NUM_INPUTS-1:0]            l_values_in,
    output logic [WIDTH*NUM_OUTPUTS*NUM_INPUTS-1:0] l_weights_in,
    output logic [WIDTH*NUM_OUTPUTS-1:0]           l_bias_in,
    output logic                                   l_valid_in,
    input  logic [WIDTH*NUM_OUTPUTS-1:0]           l_values_out,
    input  logic [NUM_OUTPUTS-1:0]                 l_valids_out,
    output logic                                   timeout_err,
    output logic                                   busy
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]                            perf_done,
    output logic [15:0]                            perf_tmo
`endif
);
    localparam int NUM_W = NUM_OUTPUTS * NUM_INPUTS;
    localparam int TOTAL = NUM_W + NUM_OUTPUTS;
    localparam int CW    = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                   state, state_next;
    logic [WIDTH*TOTAL-1:0]   cfg_regs;
    logic [NUM_OUTPUTS-1:0]   mask, mask_next, capture;
    logic [CW-1:0]            cnt, cnt_next;
    logic                     accept;
    logic                     cfg_ok;

    // Weights occupy the low words, biases the words above them.
    assign l_weights_in   = cfg_regs[WIDTH*NUM_W-1:0];
    assign l_bias_in      = cfg_regs[WIDTH*TOTAL-1:WIDTH*NUM_W];
    assign l_valid_in     = (state == S_FIRE);
    assign bus.out_valid  = (state == S_HOLD);
    assign busy           = (state != S_IDLE);
    assign accept         = (state == S_IDLE) && bus.in_valid && bus.in_ready;
    assign cfg_ok         = bus.cfg_we && (state == S_IDLE) && (int'(bus.cfg_addr) < TOTAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mask_next   = mask;
        cnt_next    = cnt;
        capture     = '0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    mask_next  = '0;
                    cnt_next   = '0;
                    state_next = S_FIRE;
                end
            end
            S_FIRE: state_next = S_WAIT;
            S_WAIT: begin
                capture   = l_valids_out & ~mask;
                mask_next = mask | l_valids_out;
                if (&mask_next) begin
                    state_next = S_HOLD;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_regs       <= '0;
            l_values_in    <= '0;
            bus.out_values <= '0;
            mask           <= '0;
            cnt            <= '0;
            bus.in_ready   <= 1'b0;
            bus.cfg_err    <= 1'b0;
        end else begin
            bus.in_ready <= (state_next == S_IDLE);
            bus.cfg_err  <= bus.cfg_we && !cfg_ok;
            mask         <= mask_next;
            cnt          <= cnt_next;
            if (accept) begin
                l_values_in <= bus.in_values;
            end
            for (int n = 0; n < NUM_OUTPUTS; n++) begin
                if (capture[n]) begin
                    bus.out_values[n*WIDTH +: WIDTH] <= l_values_out[n*WIDTH +: WIDTH];
                end
            end
            for (int i = 0; i < TOTAL; i++) begin
                if (cfg_ok && (int'(bus.cfg_addr) == i)) begin
                    cfg_regs[i*WIDTH +: WIDTH] <= bus.cfg_wdata;
                end
            end
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_done <= '0;
            perf_tmo  <= '0;
        end else begin
            if ((state == S_HOLD) && bus.out_ready && (perf_done != '1)) begin
                perf_done <= perf_done + 1'b1;
            end
            if (timeout_err && (perf_tmo != '1)) begin
                perf_tmo <= perf_tmo + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
